// File: rtl/pic10_datapath.sv
// PIC10 baseline datapath slice: program counter, instruction register and the
// combinational 8-bit ALU decoded from the instruction register.
module pic10_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_pc,
    input  logic        load_ir_reg,
    input  logic [11:0] program_mux_bus,
    input  logic [7:0]  w_reg_bus,
    input  logic [7:0]  alu_mux_bus,
    input  logic        carry_bit,
    output logic [8:0]  pc_bus,
    output logic [11:0] ir_reg_bus,
    output logic [7:0]  alu_bus,
    output logic        load_z,
    output logic        load_c,
    output logic        load_dc,
    output logic [2:0]  alu_status_bus
);

    logic [8:0]  pc_q, pc_d;
    logic [11:0] ir_q, ir_d;

    always_comb begin
        pc_d = pc_q;
        if (inc_pc) pc_d = pc_q + 9'd1;
        ir_d = ir_q;
        if (load_ir_reg) ir_d = program_mux_bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= 9'h000;
            ir_q <= 12'h000;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign pc_bus     = pc_q;
    assign ir_reg_bus = ir_q;

    logic [7:0] w, f, k, bit_mask;
    logic [8:0] add_sum, sub_sum;
    logic [4:0] add_nib, sub_nib;
    logic       c_val, dc_val;

    assign w        = w_reg_bus;
    assign f        = alu_mux_bus;
    assign k        = ir_q[7:0];
    assign bit_mask = 8'd1 << ir_q[7:5];

    // Subtraction is F + ~W + 1, so carry out doubles as the "no borrow" flag.
    assign add_sum = {1'b0, w} + {1'b0, f};
    assign add_nib = {1'b0, w[3:0]} + {1'b0, f[3:0]};
    assign sub_sum = {1'b0, f} + {1'b0, ~w} + 9'd1;
    assign sub_nib = {1'b0, f[3:0]} + {1'b0, ~w[3:0]} + 5'd1;

    always_comb begin
        alu_bus = f;
        load_z  = 1'b0;
        load_c  = 1'b0;
        load_dc = 1'b0;
        c_val   = 1'b0;
        dc_val  = 1'b0;
        casez (ir_q)
            12'b0000_0000_0000,                     // NOP
            12'b0000_0000_0010,                     // OPTION
            12'b0000_0000_0011,                     // SLEEP
            12'b0000_0000_0100,                     // CLRWDT
            12'b0000_0000_0101,
            12'b0000_0000_011?:                     // TRIS
                alu_bus = w;
            12'b0000_001?_????: alu_bus = w;        // MOVWF
            12'b0000_0100_0000: begin               // CLRW
                alu_bus = 8'h00;
                load_z  = 1'b1;
            end
            12'b0000_011?_????: begin               // CLRF
                alu_bus = 8'h00;
                load_z  = 1'b1;
            end
            12'b0000_10??_????: begin               // SUBWF
                alu_bus = sub_sum[7:0];
                c_val   = sub_sum[8];
                dc_val  = sub_nib[4];
                load_z  = 1'b1;
                load_c  = 1'b1;
                load_dc = 1'b1;
            end
            12'b0000_11??_????: begin               // DECF
                alu_bus = f - 8'd1;
                load_z  = 1'b1;
            end
            12'b0001_00??_????: begin               // IORWF
                alu_bus = w | f;
                load_z  = 1'b1;
            end
            12'b0001_01??_????: begin               // ANDWF
                alu_bus = w & f;
                load_z  = 1'b1;
            end
            12'b0001_10??_????: begin               // XORWF
                alu_bus = w ^ f;
                load_z  = 1'b1;
            end
            12'b0001_11??_????: begin               // ADDWF
                alu_bus = add_sum[7:0];
                c_val   = add_sum[8];
                dc_val  = add_nib[4];
                load_z  = 1'b1;
                load_c  = 1'b1;
                load_dc = 1'b1;
            end
            12'b0010_00??_????: begin               // MOVF
                alu_bus = f;
                load_z  = 1'b1;
            end
            12'b0010_01??_????: begin               // COMF
                alu_bus = ~f;
                load_z  = 1'b1;
            end
            12'b0010_10??_????: begin               // INCF
                alu_bus = f + 8'd1;
                load_z  = 1'b1;
            end
            12'b0010_11??_????: alu_bus = f - 8'd1; // DECFSZ
            12'b0011_00??_????: begin               // RRF
                alu_bus = {carry_bit, f[7:1]};
                c_val   = f[0];
                load_c  = 1'b1;
            end
            12'b0011_01??_????: begin               // RLF
                alu_bus = {f[6:0], carry_bit};
                c_val   = f[7];
                load_c  = 1'b1;
            end
            12'b0011_10??_????: alu_bus = {f[3:0], f[7:4]};  // SWAPF
            12'b0011_11??_????: alu_bus = f + 8'd1;          // INCFSZ
            12'b0100_????_????: alu_bus = f & ~bit_mask;     // BCF
            12'b0101_????_????: alu_bus = f | bit_mask;      // BSF
            12'b011?_????_????: alu_bus = f;                 // BTFSC/BTFSS
            12'b1000_????_????: alu_bus = k;                 // RETLW
            12'b1001_????_????,                              // CALL
            12'b101?_????_????: alu_bus = w;                 // GOTO
            12'b1100_????_????: alu_bus = k;                 // MOVLW
            12'b1101_????_????: begin                        // IORLW
                alu_bus = w | k;
                load_z  = 1'b1;
            end
            12'b1110_????_????: begin                        // ANDLW
                alu_bus = w & k;
                load_z  = 1'b1;
            end
            12'b1111_????_????: begin                        // XORLW
                alu_bus = w ^ k;
                load_z  = 1'b1;
            end
            default: alu_bus = f;
        endcase
    end

    assign alu_status_bus = {(alu_bus == 8'h00), dc_val, c_val};

endmodule

// File: tb/tb_pic10_datapath.sv
// Directed self-checking bench for pic10_datapath: PC/IR sequencing and ALU decode.
module tb_pic10_datapath;

    logic        clk = 1'b0;
    logic        reset, inc_pc, load_ir_reg, carry_bit;
    logic [11:0] program_mux_bus;
    logic [7:0]  w_reg_bus, alu_mux_bus;
    logic [8:0]  pc_bus;
    logic [11:0] ir_reg_bus;
    logic [7:0]  alu_bus;
    logic        load_z, load_c, load_dc;
    logic [2:0]  alu_status_bus;

    int total = 0;
    int bad   = 0;

    pic10_datapath dut (
        .clk             (clk),
        .reset           (reset),
        .inc_pc          (inc_pc),
        .load_ir_reg     (load_ir_reg),
        .program_mux_bus (program_mux_bus),
        .w_reg_bus       (w_reg_bus),
        .alu_mux_bus     (alu_mux_bus),
        .carry_bit       (carry_bit),
        .pc_bus          (pc_bus),
        .ir_reg_bus      (ir_reg_bus),
        .alu_bus         (alu_bus),
        .load_z          (load_z),
        .load_c          (load_c),
        .load_dc         (load_dc),
        .alu_status_bus  (alu_status_bus)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic load_ir(input logic [11:0] v);
        @(negedge clk);
        program_mux_bus = v;
        load_ir_reg = 1'b1;
        @(posedge clk);
        #1 load_ir_reg = 1'b0;
    endtask

    // Applies operands, then compares ALU result, status and {load_z,load_c,load_dc}.
    task automatic alu_case(input string name, input logic [11:0] ir, input logic [7:0] w,
                            input logic [7:0] f, input logic c, input logic [7:0] exp_alu,
                            input logic [2:0] exp_st, input logic [2:0] exp_ld);
        load_ir(ir);
        w_reg_bus = w;
        alu_mux_bus = f;
        carry_bit = c;
        #1;
        total++;
        if (alu_bus !== exp_alu) begin
            bad++;
            $display("FAIL %s alu_bus got=%h want=%h", name, alu_bus, exp_alu);
        end
        total++;
        if (alu_status_bus !== exp_st) begin
            bad++;
            $display("FAIL %s status got=%b want=%b", name, alu_status_bus, exp_st);
        end
        total++;
        if ({load_z, load_c, load_dc} !== exp_ld) begin
            bad++;
            $display("FAIL %s loads got=%b want=%b", name, {load_z, load_c, load_dc}, exp_ld);
        end
    endtask

    task automatic test_reset;
        do_reset(3);
        total++;
        if (pc_bus !== 9'h000) begin
            bad++;
            $display("FAIL reset_pc got=%h want=000", pc_bus);
        end
        total++;
        if (ir_reg_bus !== 12'h000) begin
            bad++;
            $display("FAIL reset_ir got=%h want=000", ir_reg_bus);
        end
    endtask

    task automatic test_pc;
        @(negedge clk);
        inc_pc = 1'b1;
        @(posedge clk);
        #1 inc_pc = 1'b0;
        total++;
        if (pc_bus !== 9'h001) begin
            bad++;
            $display("FAIL pc_inc got=%h want=001", pc_bus);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pc_bus !== 9'h001) begin
            bad++;
            $display("FAIL pc_hold got=%h want=001", pc_bus);
        end
        do_reset(1);
        @(negedge clk);
        inc_pc = 1'b1;
        repeat (511) @(posedge clk);
        #1;
        total++;
        if (pc_bus !== 9'h1FF) begin
            bad++;
            $display("FAIL pc_top got=%h want=1ff", pc_bus);
        end
        @(posedge clk);
        #1 inc_pc = 1'b0;
        total++;
        if (pc_bus !== 9'h000) begin
            bad++;
            $display("FAIL pc_wrap got=%h want=000", pc_bus);
        end
    endtask

    task automatic test_ir;
        load_ir(12'hABC);
        total++;
        if (ir_reg_bus !== 12'hABC) begin
            bad++;
            $display("FAIL ir_load got=%h want=abc", ir_reg_bus);
        end
        program_mux_bus = 12'h123;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ir_reg_bus !== 12'hABC) begin
            bad++;
            $display("FAIL ir_hold got=%h want=abc", ir_reg_bus);
        end
        do_reset(1);
        total++;
        if (ir_reg_bus !== 12'h000) begin
            bad++;
            $display("FAIL ir_reset got=%h want=000", ir_reg_bus);
        end
    endtask

    task automatic test_arith;
        alu_case("addwf_c",   12'h1C0, 8'hF0, 8'h16, 1'b0, 8'h06, 3'b001, 3'b111);
        alu_case("addwf_dc",  12'h1C0, 8'h0F, 8'h01, 1'b0, 8'h10, 3'b010, 3'b111);
        alu_case("addwf_z",   12'h1C0, 8'hFF, 8'h01, 1'b0, 8'h00, 3'b111, 3'b111);
        alu_case("subwf_brw", 12'h080, 8'h05, 8'h03, 1'b0, 8'hFE, 3'b000, 3'b111);
        alu_case("subwf_eq",  12'h080, 8'h03, 8'h03, 1'b0, 8'h00, 3'b111, 3'b111);
        alu_case("incf_wrap", 12'h280, 8'h00, 8'hFF, 1'b0, 8'h00, 3'b100, 3'b100);
        alu_case("decf_wrap", 12'h0C0, 8'h00, 8'h00, 1'b0, 8'hFF, 3'b000, 3'b100);
    endtask

    task automatic test_rotate_bits;
        alu_case("rlf",   12'h340, 8'h00, 8'h80, 1'b0, 8'h00, 3'b101, 3'b010);
        alu_case("rrf",   12'h300, 8'h00, 8'h01, 1'b1, 8'h80, 3'b001, 3'b010);
        alu_case("swapf", 12'h380, 8'h00, 8'hA5, 1'b0, 8'h5A, 3'b000, 3'b000);
        alu_case("bsf",   12'h560, 8'h00, 8'h00, 1'b0, 8'h08, 3'b000, 3'b000);
        alu_case("bcf",   12'h4E0, 8'h00, 8'hFF, 1'b0, 8'h7F, 3'b000, 3'b000);
        alu_case("comf",  12'h240, 8'h00, 8'h0F, 1'b0, 8'hF0, 3'b000, 3'b100);
    endtask

    task automatic test_literal_misc;
        alu_case("movlw",  12'hC5A, 8'h11, 8'h22, 1'b0, 8'h5A, 3'b000, 3'b000);
        alu_case("andlw",  12'hE0F, 8'h3C, 8'h00, 1'b0, 8'h0C, 3'b000, 3'b100);
        alu_case("xorlw",  12'hF3C, 8'h3C, 8'h55, 1'b0, 8'h00, 3'b100, 3'b100);
        alu_case("clrf",   12'h060, 8'h12, 8'h34, 1'b0, 8'h00, 3'b100, 3'b100);
        alu_case("movwf",  12'h025, 8'h9A, 8'h34, 1'b0, 8'h9A, 3'b000, 3'b000);
        alu_case("nop",    12'h000, 8'h77, 8'h34, 1'b0, 8'h77, 3'b000, 3'b000);
        alu_case("goto",   12'hA12, 8'h66, 8'h34, 1'b0, 8'h66, 3'b000, 3'b000);
        alu_case("undef",  12'h001, 8'h77, 8'h3C, 1'b0, 8'h3C, 3'b000, 3'b000);
    endtask

    task automatic test_reset_vs_load;
        load_ir(12'h1C0);
        w_reg_bus = 8'h42;
        alu_mux_bus = 8'h01;
        @(negedge clk);
        reset = 1'b1;
        load_ir_reg = 1'b1;
        program_mux_bus = 12'hC5A;
        @(posedge clk);
        #1;
        reset = 1'b0;
        load_ir_reg = 1'b0;
        total++;
        if (ir_reg_bus !== 12'h000) begin
            bad++;
            $display("FAIL reset_wins_ir got=%h want=000", ir_reg_bus);
        end
        total++;
        if (alu_bus !== 8'h42 || {load_z, load_c, load_dc} !== 3'b000) begin
            bad++;
            $display("FAIL reset_nop_alu got=%h/%b want=42/000", alu_bus,
                     {load_z, load_c, load_dc});
        end
    endtask

    initial begin
        reset = 1'b0;
        inc_pc = 1'b0;
        load_ir_reg = 1'b0;
        carry_bit = 1'b0;
        program_mux_bus = 12'h000;
        w_reg_bus = 8'h00;
        alu_mux_bus = 8'h00;
        test_reset;
        test_pc;
        test_ir;
        test_arith;
        test_rotate_bits;
        test_literal_misc;
        test_reset_vs_load;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
